// File: rtl/dispchar_pkg.sv
// Shared types and constants for the character pixel generator.
// Glyph geometry and the default RGB565 palette live here.
package dispchar_pkg;

    localparam int GLYPH_W = 32;
    localparam int GLYPH_H = 64;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam logic [15:0] DEF_FG = 16'hFFFF;
    localparam logic [15:0] DEF_BG = 16'h001F;

    function automatic rgb565_t to_rgb(input logic [15:0] c);
        return rgb565_t'(c);
    endfunction

endpackage

// File: rtl/char_pixel_gen_blink_timer.sv
// Frame counter that toggles the glyph blink phase every
// BLINK_FRAMES falling edges of the active-low vertical sync.
module blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic vsy_in,
    output logic phase
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

    logic [CW-1:0] cnt;
    logic          vsy_q;
    logic          fall;

    assign fall = vsy_q & ~vsy_in;

    // phase=1 means the glyph is visible
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            vsy_q <= 1'b1;
            phase <= 1'b1;
        end else begin
            vsy_q <= vsy_in;
            if (fall) begin
                if (cnt == LAST) begin
                    cnt   <= '0;
                    phase <= ~phase;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/char_pixel_gen.sv
// Three-stage glyph overlay: window test, ROM fetch, colour select.
// Define CHAR_BLINK_EN to add the vsync-driven blink timer.
module char_pixel_gen
    import dispchar_pkg::*;
#(
    parameter int          H_ORG        = 100,
    parameter int          V_ORG        = 50,
    parameter logic [15:0] FG_COLOR     = DEF_FG,
    parameter logic [15:0] BG_COLOR     = DEF_BG,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de_in,
    input  logic        hsy_in,
    input  logic        vsy_in,
    input  logic [9:0]  hcnt,
    input  logic [9:0]  vcnt,
    output logic [5:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic        de_out,
    output logic        hsy_out,
    output logic        vsy_out,
    output logic [4:0]  lcd_r,
    output logic [5:0]  lcd_g,
    output logic [4:0]  lcd_b
);

    localparam logic [10:0] H_LO  = 11'(H_ORG);
    localparam logic [10:0] H_HI  = 11'(H_ORG + GLYPH_W);
    localparam logic [10:0] V_LO  = 11'(V_ORG);
    localparam logic [10:0] V_HI  = 11'(V_ORG + GLYPH_H);
    localparam logic [4:0]  H_OFF = 5'(H_ORG);
    localparam logic [5:0]  V_OFF = 6'(V_ORG);

    logic       in_win;
    logic       visible;
    logic       glyph_bit;

    logic [4:0] s1_col;
    logic       s1_win, s1_de, s1_hs, s1_vs;
    logic [4:0] s2_col;
    logic       s2_win, s2_de, s2_hs, s2_vs;

    rgb565_t    pix_d;
    rgb565_t    pix;

`ifdef CHAR_BLINK_EN
    blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk   (clk),
        .rst   (rst),
        .vsy_in(vsy_in),
        .phase (visible)
    );
`else
    assign visible = (BLINK_FRAMES != 0) | 1'b1;
`endif

    assign in_win = de_in
                  && ({1'b0, hcnt} >= H_LO) && ({1'b0, hcnt} < H_HI)
                  && ({1'b0, vcnt} >= V_LO) && ({1'b0, vcnt} < V_HI);

    // Offsets are modulo glyph size; only meaningful inside the window
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            s1_col   <= '0;
            s1_win   <= 1'b0;
            s1_de    <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
        end else begin
            rom_addr <= in_win ? (vcnt[5:0] - V_OFF) : '0;
            s1_col   <= in_win ? (hcnt[4:0] - H_OFF) : '0;
            s1_win   <= in_win;
            s1_de    <= de_in;
            s1_hs    <= hsy_in;
            s1_vs    <= vsy_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_col <= '0;
            s2_win <= 1'b0;
            s2_de  <= 1'b0;
            s2_hs  <= 1'b1;
            s2_vs  <= 1'b1;
        end else begin
            s2_col <= s1_col;
            s2_win <= s1_win;
            s2_de  <= s1_de;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
        end
    end

    // Leftmost pixel maps to the MSB of the ROM word
    assign glyph_bit = rom_data[5'(GLYPH_W - 1) - s2_col];

    always_comb begin
        pix_d = '0;
        if (s2_de) begin
            if (s2_win && glyph_bit && visible)
                pix_d = to_rgb(FG_COLOR);
            else
                pix_d = to_rgb(BG_COLOR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix     <= '0;
            de_out  <= 1'b0;
            hsy_out <= 1'b1;
            vsy_out <= 1'b1;
        end else begin
            pix     <= pix_d;
            de_out  <= s2_de;
            hsy_out <= s2_hs;
            vsy_out <= s2_vs;
        end
    end

    assign lcd_r = pix.r;
    assign lcd_g = pix.g;
    assign lcd_b = pix.b;

endmodule

// File: tb/tb_char_pixel_gen.sv
// Bench for char_pixel_gen: pixel-level reference model plus
// directed literal vectors; blink cases under CHAR_BLINK_EN.
module tb_char_pixel_gen;

    localparam int          H  = 100;
    localparam int          V  = 50;
    localparam logic [15:0] FG = 16'hFFFF;
    localparam logic [15:0] BG = 16'h001F;
`ifdef CHAR_BLINK_EN
    localparam int          BF = 30;
`endif

    logic        clk;
    logic        rst;
    logic        de_in, hsy_in, vsy_in;
    logic [9:0]  hcnt, vcnt;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic        de_out, hsy_out, vsy_out;
    logic [4:0]  lcd_r;
    logic [5:0]  lcd_g;
    logic [4:0]  lcd_b;

    int checks   = 0;
    int failures = 0;

    char_pixel_gen dut (
        .clk     (clk),
        .rst     (rst),
        .de_in   (de_in),
        .hsy_in  (hsy_in),
        .vsy_in  (vsy_in),
        .hcnt    (hcnt),
        .vcnt    (vcnt),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .de_out  (de_out),
        .hsy_out (hsy_out),
        .vsy_out (vsy_out),
        .lcd_r   (lcd_r),
        .lcd_g   (lcd_g),
        .lcd_b   (lcd_b)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Glyph ROM with registered address
    always @(posedge clk) rom_data <= 32'h8000_0001 << (rom_addr % 8);

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Pixel rule: row r lights column 31-(r%8); rows with r%8==0 also column 0
    function automatic bit glyph_on(input int r, input int c);
        int m;
        m = r % 8;
        return (c == 31 - m) || (m == 0 && c == 0);
    endfunction

    function automatic bit blink_vis(input int e);
`ifdef CHAR_BLINK_EN
        return ((e / BF) % 2) == 0;
`else
        return (e >= 0);
`endif
    endfunction

    typedef struct {
        bit de;
        bit on;
        bit hs;
        bit vs;
    } ent_t;

    ent_t        q[$];
    logic [15:0] exp_col;
    logic        exp_de, exp_hs, exp_vs;
    logic [5:0]  exp_addr;
    int          edges;
    bit          prev_vs;
    bit          model_ok = 0;

    always @(posedge clk) begin
        int  h, v;
        bit  win, vis;
        ent_t e;
        if (rst) begin
            q.delete();
            exp_col  = 16'h0000;
            exp_de   = 1'b0;
            exp_hs   = 1'b1;
            exp_vs   = 1'b1;
            exp_addr = 6'd0;
            edges    = 0;
            prev_vs  = 1'b1;
            model_ok = 1;
        end else begin
            vis = blink_vis(edges);
            h   = int'(hcnt);
            v   = int'(vcnt);
            win = de_in && h >= H && h < H + 32 && v >= V && v < V + 64;
            q.push_back('{de_in, win && glyph_on(v - V, h - H),
                          hsy_in, vsy_in});
            if (q.size() == 3) begin
                e       = q.pop_front();
                exp_de  = e.de;
                exp_hs  = e.hs;
                exp_vs  = e.vs;
                exp_col = !e.de ? 16'h0000 : ((e.on && vis) ? FG : BG);
            end
            exp_addr = win ? 6'(v - V) : 6'd0;
            if (prev_vs && !vsy_in) edges++;
            prev_vs = vsy_in;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("colour",   {lcd_r, lcd_g, lcd_b}, exp_col);
            chk("de_out",   de_out,   exp_de);
            chk("hsy_out",  hsy_out,  exp_hs);
            chk("vsy_out",  vsy_out,  exp_vs);
            chk("rom_addr", rom_addr, exp_addr);
        end
    end

    task automatic lit(input int h, input int v, input bit d,
                       input logic [5:0] ea, input logic [15:0] ec,
                       input string nm);
        hcnt  = 10'(h);
        vcnt  = 10'(v);
        de_in = d;
        @(negedge clk);
        chk({nm, "_addr"}, rom_addr, ea);
        de_in = 1'b0;
        hcnt  = 10'd0;
        vcnt  = 10'd0;
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_col"}, {lcd_r, lcd_g, lcd_b}, ec);
    endtask

`ifdef CHAR_BLINK_EN
    task automatic vs_edges(input int n);
        for (int i = 0; i < n; i++) begin
            de_in  = 1'b0;
            vsy_in = 1'b0;
            @(negedge clk);
            vsy_in = 1'b1;
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        de_in  = 1'b1;
        hsy_in = 1'b0;
        vsy_in = 1'b0;
        hcnt   = 10'd100;
        vcnt   = 10'd50;
        repeat (5) @(negedge clk);
        chk("rst_addr", rom_addr, 6'd0);
        chk("rst_col",  {lcd_r, lcd_g, lcd_b}, 16'h0000);
        chk("rst_de",   de_out,  1'b0);
        chk("rst_hsy",  hsy_out, 1'b1);
        chk("rst_vsy",  vsy_out, 1'b1);
        de_in  = 1'b0;
        hsy_in = 1'b1;
        vsy_in = 1'b1;
        rst    = 1'b0;
        repeat (3) @(negedge clk);

        lit(100,  50, 1'b1, 6'd0,  16'hFFFF, "origin");
        lit(132,  50, 1'b1, 6'd0,  16'h001F, "right_out");
        lit(131,  50, 1'b1, 6'd0,  16'hFFFF, "right_in");
        lit(110,  50, 1'b0, 6'd0,  16'h0000, "de_low");
        lit( 99,  50, 1'b1, 6'd0,  16'h001F, "left_out");
        lit(101,  51, 1'b1, 6'd1,  16'h001F, "row1_c1");
        lit(130,  51, 1'b1, 6'd1,  16'hFFFF, "row1_c30");
        lit(100, 113, 1'b1, 6'd63, 16'h001F, "row63_c0");
        lit(124, 113, 1'b1, 6'd63, 16'hFFFF, "row63_c24");
        lit(100, 114, 1'b1, 6'd0,  16'h001F, "bottom_out");
        lit(100,  49, 1'b1, 6'd0,  16'h001F, "top_out");

        for (int i = 0; i < 300; i++) begin
            hsy_in = 1'($urandom);
            vsy_in = 1'($urandom);
            de_in  = ($urandom_range(0, 3) != 0);
            hcnt   = 10'($urandom_range(90, 140));
            vcnt   = 10'($urandom_range(40, 120));
            rst    = (i >= 150 && i < 152);
            @(negedge clk);
        end
        rst    = 1'b0;
        de_in  = 1'b0;
        hsy_in = 1'b1;
        vsy_in = 1'b1;
        repeat (4) @(negedge clk);

`ifdef CHAR_BLINK_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vs_edges(30);
        lit(100, 50, 1'b1, 6'd0, BG, "blink_off");
        vs_edges(30);
        lit(100, 50, 1'b1, 6'd0, FG, "blink_on");
        vs_edges(15);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vs_edges(15);
        lit(100, 50, 1'b1, 6'd0, FG, "blink_rst");
        repeat (4) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/char_pixel_gen.md
CHAR_PIXEL_GEN -- requirements
Module: char_pixel_gen

Interface
REQ-001 Parameter H_ORG, default 100, glyph window left column in pixels.
REQ-002 Parameter V_ORG, default 50, glyph window top row in lines.
REQ-003 Parameter FG_COLOR, default 16'hFFFF, RGB565 colour for glyph pixels that are set.
REQ-004 Parameter BG_COLOR, default 16'h001F, RGB565 colour for every other pixel.
REQ-005 Parameter BLINK_FRAMES, default 30, number of frames per blink half-period.
REQ-006 clk  in  1  pixel clock (25 MHz); the only clock in the block.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 de_in  in  1  active-video flag from the timing generator.
REQ-009 hsy_in, vsy_in  in  1 each  syncs from the timing generator; both active-low.
REQ-010 hcnt, vcnt  in  10 each  active-area pixel column and line.
REQ-011 rom_addr  out  6  glyph ROM row address.
REQ-012 rom_data  in  32  glyph ROM word; q is valid one clk after the address is sampled.
REQ-013 de_out, hsy_out, vsy_out  out  1 each  delayed copies of de_in, hsy_in, vsy_in.
REQ-014 lcd_r/lcd_g/lcd_b  out  5/6/5  pixel colour.

Function
REQ-015 The glyph window SHALL be H_ORG <= hcnt < H_ORG+32 and V_ORG <= vcnt < V_ORG+64, with de_in=1.
REQ-016 Stage 1 SHALL register rom_addr = vcnt-V_ORG (6 bits) when in the window, otherwise 0.
REQ-017 Stage 1 SHALL also register col = hcnt-H_ORG (5 bits) and the in-window flag.
REQ-018 Stage 2 SHALL carry col and the in-window flag alongside the ROM word, which arrives during stage 2.
REQ-019 Stage 3 SHALL register the colour: FG_COLOR if in-window and rom_data[31-col]=1 and the blink phase is visible, else BG_COLOR.
REQ-020 When de is 0 at stage 3, the colour output SHALL be 16'h0000.
REQ-021 Latency from inputs to colour, de_out, hsy_out and vsy_out SHALL be exactly 3 clk, identical for all outputs.
REQ-022 The pipeline SHALL accept a new pixel every clk, with no stalls.
REQ-023 Window edges are inclusive at the origin and exclusive at the origin plus glyph size: hcnt=H_ORG+31 is in the window, hcnt=H_ORG+32 is not.
REQ-024 Subtraction SHALL use truncated unsigned arithmetic, valid only when the window test passes.
REQ-025 Coordinates outside the window SHALL never select a glyph bit.

Reset
REQ-026 While rst=1, at the next clk edge, all pipeline registers, rom_addr, de_out and colour SHALL go to 0.
REQ-027 While rst=1, hsy_out and vsy_out SHALL go to 1 (inactive).
REQ-028 After rst deasserts mid-frame, outputs SHALL be correct from the 4th clk onward; the first 3 clk output reset values.
REQ-029 Reset SHALL clear the blink counter to 0 and set the blink phase to visible.

Configuration
REQ-030 Macro CHAR_BLINK_EN, when defined, SHALL enable a frame counter that increments on each vsy_in 1->0 transition.
REQ-031 With CHAR_BLINK_EN, the counter SHALL wrap to 0 after BLINK_FRAMES-1 and toggle the blink phase on wrap.
REQ-032 With CHAR_BLINK_EN, a phase change SHALL take effect for stage-3 pixels from the clk after the detected edge.
REQ-033 Without CHAR_BLINK_EN, there SHALL be no counter logic and the blink phase SHALL be constant visible.

Structure
REQ-034 Package dispchar_pkg SHALL hold the rgb565 typedef, GLYPH_W=32, GLYPH_H=64, and the default FG and BG colour constants.
REQ-035 Blink logic SHALL be a sub-module blink_timer (clk, rst, vsy_in, phase), instantiated only under CHAR_BLINK_EN.

Verification
REQ-036 The bench SHALL model the ROM with 1-clk registered-address latency, row r = 32'h8000_0001 << (r%8).
REQ-037 Scenario: reset held 5 clk -> rom_addr=0, colour=0, de_out=0, hsy_out=vsy_out=1.
REQ-038 Scenario: hcnt=100, vcnt=50, de=1, row 0 = 32'h8000_0001 -> rom_addr=0 one clk later; colour=16'hFFFF three clk after the input.
REQ-039 Scenario: hcnt=132, vcnt=50 -> colour=16'h001F; hcnt=131 -> 16'hFFFF (bit 0 set).
REQ-040 Scenario: de=0 at hcnt=110 -> colour=16'h0000 three clk later.
REQ-041 Scenario (CHAR_BLINK_EN): 30 vsync falling edges -> window pixels show BG_COLOR; 60 edges -> FG_COLOR again; rst at edge 15 -> counter restarts and phase is visible.
REQ-042 Scenario: random hsy_in/vsy_in toggles -> hsy_out/vsy_out equal the inputs delayed exactly 3 clk.
